ram_burst_reader: RTL and testbench

//  Client/initiator side of a single-port block RAM (1-cycle registered read, write-through q).

---
 rtl/ram_burst_reader.sv | 183 ++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst reader for a single-port block RAM: streams sequential reads out on valid/ready
// while host writes steal RAM cycles. Define RAMRD_INIT_CLEAR_EN to zero the RAM after reset.
module ram_burst_reader #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [addr_width_g-1:0] start_addr,
  input  logic [addr_width_g:0]   burst_len,
  output logic                    busy,
  output logic                    done,
  output logic [data_width_g-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    host_wr,
  input  logic [addr_width_g-1:0] host_addr,
  input  logic [data_width_g-1:0] host_data,
  output logic                    host_ack,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q
);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN, ST_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [addr_width_g-1:0] ptr_q, ptr_d;
  logic [addr_width_g:0]   remaining_q, remaining_d;
  logic                    inflight_q, inflight_d;
  logic [data_width_g-1:0] fifo_q [2];
  logic [data_width_g-1:0] fifo_d [2];
  logic                    wr_sel_q, wr_sel_d;
  logic                    rd_sel_q, rd_sel_d;
  logic [1:0]              count_q, count_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
`ifdef RAMRD_INIT_CLEAR_EN
  logic [addr_width_g-1:0] clear_addr_q, clear_addr_d;
`endif

  logic       pop;
  logic       issue;
  logic [1:0] credit;

  // A word popped this cycle frees its slot before the next push, which keeps 1 word/cycle.
  always_comb begin
    pop    = (count_q != 2'd0) && out_ready;
    credit = count_q - {1'b0, pop} + {1'b0, inflight_q};
    issue  = (state_q == ST_BURST) && (remaining_q != '0) && !host_wr && (credit < 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    fifo_d      = fifo_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    done_d      = 1'b0;
`ifdef RAMRD_INIT_CLEAR_EN
    clear_addr_d = clear_addr_q;
`endif

    if (inflight_q) begin
      fifo_d[wr_sel_q] = ram_q;
      wr_sel_d         = ~wr_sel_q;
    end
    if (pop) rd_sel_d = ~rd_sel_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    if (issue) begin
      ptr_d       = ptr_q + addr_width_g'(1);
      remaining_d = remaining_q - (addr_width_g + 1)'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d     = ST_BURST;
            ptr_d       = start_addr;
            remaining_d = burst_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if ((remaining_q == '0) && !inflight_q) begin
          if (count_d == 2'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (count_d == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
`ifdef RAMRD_INIT_CLEAR_EN
        if (!host_wr) begin
          clear_addr_d = clear_addr_q + addr_width_g'(1);
          if (clear_addr_q == '1) state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Host writes always win the RAM port; clearing only uses cycles the host leaves free.
  always_comb begin
    ram_address = ptr_q;
    ram_data    = '0;
    ram_wren    = 1'b0;
`ifdef RAMRD_INIT_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_address = clear_addr_q;
      ram_wren    = 1'b1;
    end
`endif
    if (host_wr) begin
      ram_address = host_addr;
      ram_data    = host_data;
      ram_wren    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef RAMRD_INIT_CLEAR_EN
      state_q      <= ST_CLEAR;
      busy_q       <= 1'b1;
      clear_addr_q <= '0;
`else
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
`endif
      ptr_q       <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      count_q     <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      fifo_q      <= fifo_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      count_q     <= count_d;
      done_q      <= done_d;
`ifdef RAMRD_INIT_CLEAR_EN
      clear_addr_q <= clear_addr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[rd_sel_q];
  assign host_ack  = host_wr;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural 2048x8 write-through RAM.
// Covers the RAMRD_INIT_CLEAR_EN build as well when that macro is defined.
module tb_ram_burst_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] burst_len;
  logic        busy;
  logic        done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        host_wr;
  logic [10:0] host_addr;
  logic [7:0]  host_data;
  logic        host_ack;
  logic [10:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q;

  logic        preWr;
  logic [10:0] preAddr;
  logic [7:0]  preData;
  logic [7:0]  mem [2048];

  int vectorsApplied = 0;
  int miscompares    = 0;

`ifdef RAMRD_INIT_CLEAR_EN
  localparam bit clearEn = 1'b1;
`else
  localparam bit clearEn = 1'b0;
`endif

  ram_burst_reader #(.addr_width_g(11), .data_width_g(8)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .busy(busy), .done(done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .host_wr(host_wr),
    .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM, registered read, write-through q; preWr is a bench-only backdoor.
  always @(posedge clock) begin
    if (preWr) mem[preAddr] <= preData;
    else if (ram_wren) begin
      mem[ram_address] <= ram_data;
      ram_q            <= ram_data;
    end else ram_q <= mem[ram_address];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic [10:0] addr;
    logic [11:0] len;
    logic [31:0] readyMask;
    logic        hostEn;
    logic [63:0] expWords;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pokeWord(input logic [10:0] a, input logic [7:0] d);
    preWr = 1'b1; preAddr = a; preData = d;
    @(negedge clock);
    preWr = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t       v;
    logic [7:0] got [16];
    int         gotN, lastPop, doneAt, firstValid;
    bit         prevStall;
    logic [7:0] prevData;
    v = vecs[idx];
    gotN = 0; lastPop = -1; doneAt = -1; firstValid = -1; prevStall = 0; prevData = 8'h00;
    @(negedge clock);
    start = 1'b1; start_addr = v.addr; burst_len = v.len;
    @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clock);
      start     = 1'b0;
      out_ready = (i < 32) ? v.readyMask[i] : 1'b1;
      if (v.hostEn && (i % 2 == 0) && (i < 16)) begin
        host_wr   = 1'b1;
        host_addr = (i == 0) ? 11'h207 : 11'h300 + 11'(i);
        host_data = (i == 0) ? 8'h99 : 8'h60 + 8'(i);
      end else host_wr = 1'b0;
      #1;
      if (host_wr) checkOutput($sformatf("v%0d host_ack i%0d", idx, i), 32'(host_ack), 32'd1);
      if (out_valid && firstValid < 0) firstValid = i;
      if (prevStall) begin
        checkOutput($sformatf("v%0d held valid i%0d", idx, i), 32'(out_valid), 32'd1);
        checkOutput($sformatf("v%0d held data i%0d", idx, i), 32'(out_data), 32'(prevData));
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      if (done) begin
        doneAt = i;
        checkOutput($sformatf("v%0d busy at done", idx), 32'(busy), 32'd0);
        break;
      end
      if (out_valid && out_ready) begin
        if (gotN < 16) got[gotN] = out_data;
        gotN++;
        lastPop = i;
      end
    end
    host_wr = 1'b0; out_ready = 1'b1;
    checkOutput($sformatf("v%0d word count", idx), 32'(gotN), 32'(v.len));
    for (int k = 0; k < int'(v.len) && k < gotN && k < 8; k++)
      checkOutput($sformatf("v%0d word%0d", idx, k), 32'(got[k]), 32'(v.expWords[8*k +: 8]));
    checkOutput($sformatf("v%0d done timing", idx), 32'(doneAt), 32'(lastPop + 1));
    if (!v.hostEn) checkOutput($sformatf("v%0d first valid", idx), 32'(firstValid), 32'd2);
    if (!v.hostEn && v.readyMask == 32'hFFFF_FFFF)
      checkOutput($sformatf("v%0d sustained rate", idx), 32'(lastPop), 32'(firstValid + int'(v.len) - 1));
    @(negedge clock); #1;
    checkOutput($sformatf("v%0d done one cycle", idx), 32'(done), 32'd0);
    if (v.hostEn)
      for (int k = 2; k < 16; k += 2)
        checkOutput($sformatf("v%0d host mem %0d", idx, k), 32'(mem[11'h300 + 11'(k)]), 32'(8'h60 + 8'(k)));
  endtask

  initial begin
    int busyCycles, wordsSeen, nonZero, badDone;
    vecs[0] = '{addr: 11'h010, len: 12'd4, readyMask: 32'hFFFF_FFFF, hostEn: 1'b0, expWords: 64'h0000_0000_A3A2_A1A0};
    vecs[1] = '{addr: 11'h7FE, len: 12'd4, readyMask: 32'hFFFF_FFFF, hostEn: 1'b0, expWords: 64'h0000_0000_E4E3_E2E1};
    vecs[2] = '{addr: 11'h100, len: 12'd6, readyMask: 32'hFFFF_000F, hostEn: 1'b0, expWords: 64'h0000_3534_3332_3130};
    vecs[3] = '{addr: 11'h200, len: 12'd8, readyMask: 32'hFFFF_FFFF, hostEn: 1'b1, expWords: 64'h9946_4544_4342_4140};
    vecs[4] = '{addr: 11'h011, len: 12'd2, readyMask: 32'hFFFF_FFFF, hostEn: 1'b0, expWords: 64'h0000_0000_0000_A2A1};
    vecs[5] = '{addr: 11'h000, len: 12'd1, readyMask: 32'hFFFF_FFFF, hostEn: 1'b0, expWords: 64'h0000_0000_0000_00E3};

    reset = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b1;
    host_wr = 1'b0; host_addr = '0; host_data = '0; preWr = 1'b0; preAddr = '0; preData = '0;
    @(negedge clock);
    for (int a = 0; a < 2048; a++) pokeWord(11'(a), 8'hFF);
    #1;
    checkOutput("reset busy", 32'(busy), 32'(clearEn));
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    reset = 1'b0;

    if (clearEn) begin
      busyCycles = 1;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clock); #1;
        if (!busy) break;
        busyCycles++;
      end
      checkOutput("clear busy cycles", 32'(busyCycles), 32'd2048);
      @(negedge clock);
      start = 1'b1; start_addr = 11'h000; burst_len = 12'd2048;
      @(negedge clock);
      start = 1'b0;
      wordsSeen = 0; nonZero = 0;
      for (int i = 0; i < 2200; i++) begin
        if (i > 0) @(negedge clock);
        #1;
        if (done) break;
        if (out_valid) begin
          wordsSeen++;
          if (out_data != 8'h00) nonZero++;
        end
      end
      checkOutput("clear words read", 32'(wordsSeen), 32'd2048);
      checkOutput("clear nonzero words", 32'(nonZero), 32'd0);
    end

    @(negedge clock);
    for (int k = 0; k < 4; k++) pokeWord(11'h010 + 11'(k), 8'hA0 + 8'(k));
    pokeWord(11'h7FE, 8'hE1); pokeWord(11'h7FF, 8'hE2);
    pokeWord(11'h000, 8'hE3); pokeWord(11'h001, 8'hE4);
    for (int k = 0; k < 6; k++) pokeWord(11'h100 + 11'(k), 8'h30 + 8'(k));
    for (int k = 0; k < 8; k++) pokeWord(11'h200 + 11'(k), 8'h40 + 8'(k));

    for (int v = 0; v < 6; v++) applyStimulus(v);

    // Zero-length burst: done pulse only.
    @(negedge clock);
    start = 1'b1; start_addr = 11'h010; burst_len = 12'd0;
    @(negedge clock);
    start = 1'b0; #1;
    checkOutput("len0 done", 32'(done), 32'd1);
    checkOutput("len0 out_valid", 32'(out_valid), 32'd0);
    checkOutput("len0 busy", 32'(busy), 32'd0);
    @(negedge clock); #1;
    checkOutput("len0 done cleared", 32'(done), 32'd0);
    checkOutput("len0 no data", 32'(out_valid), 32'd0);

    // Reset while the FIFO holds unread words.
    out_ready = 1'b0;
    start = 1'b1; start_addr = 11'h010; burst_len = 12'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    checkOutput("midburst valid before reset", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock); #1;
    checkOutput("midburst reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midburst reset busy", 32'(busy), 32'(clearEn));
    checkOutput("midburst reset done", 32'(done), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    badDone = 0;
    repeat (10) begin
      @(negedge clock); #1;
      if (done || out_valid) badDone++;
    end
    checkOutput("midburst no done or data", 32'(badDone), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
